hms_time_counter: RTL and testbench

//   Registered hours:minutes:seconds counter for the digital clock; consumes the
//   3-bit tens-digit increment path and feeds the display decoders.
//   - Divides clk down to a 1 Hz internal tick.
//   - Advances BCD-style digits with cascaded rollover.
//   - Supports manual minute/hour adjustment in set mode.

---
 rtl/hms_time_counter.sv | 167 ++++++++++++++++
 tb/tb_hms_time_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hms_time_counter.sv
// Hours:minutes:seconds counter with a 1 Hz prescaler, cascaded digit
// rollover and a set mode for manual minute/hour adjustment.
module hms_time_counter #(
   parameter int unsigned CLK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       set_mode,
   input  logic       set_field,
   input  logic       adj,
   output logic [3:0] sec_o,
   output logic [2:0] sec_t,
   output logic [3:0] min_o,
   output logic [2:0] min_t,
   output logic [3:0] hr_o,
   output logic [1:0] hr_t,
   output logic       sec_pulse,
   output logic       day_wrap
);

   localparam int unsigned PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic          set_mode_q;
   logic [3:0]    sec_o_q, sec_o_d, min_o_q, min_o_d, hr_o_q, hr_o_d;
   logic [2:0]    sec_t_q, sec_t_d, min_t_q, min_t_d;
   logic [1:0]    hr_t_q, hr_t_d;
   logic          sec_pulse_q, sec_pulse_d, day_wrap_q, day_wrap_d;
   logic          tick;

   // Incremented digit pairs; ">=" limit compares make out-of-range values recover to 0.
   logic [3:0] sec_o_inc, min_o_inc, hr_o_inc;
   logic [2:0] sec_t_inc, min_t_inc;
   logic [1:0] hr_t_inc;
   logic       sec_carry, min_carry, hr_wrap;

   // +1 on each field, with carry/wrap flags out of the field
   always_comb begin
      sec_o_inc = sec_o_q + 4'd1;
      sec_t_inc = sec_t_q;
      sec_carry = 1'b0;
      if (sec_o_q >= 4'd9) begin
         sec_o_inc = '0;
         if (sec_t_q >= 3'd5) begin
            sec_t_inc = '0;
            sec_carry = 1'b1;
         end else begin
            sec_t_inc = sec_t_q + 3'd1;
         end
      end

      min_o_inc = min_o_q + 4'd1;
      min_t_inc = min_t_q;
      min_carry = 1'b0;
      if (min_o_q >= 4'd9) begin
         min_o_inc = '0;
         if (min_t_q >= 3'd5) begin
            min_t_inc = '0;
            min_carry = 1'b1;
         end else begin
            min_t_inc = min_t_q + 3'd1;
         end
      end

      hr_o_inc = hr_o_q + 4'd1;
      hr_t_inc = hr_t_q;
      hr_wrap  = 1'b0;
      if (hr_t_q > 2'd2 || (hr_t_q == 2'd2 && hr_o_q >= 4'd3)) begin
         hr_o_inc = '0;
         hr_t_inc = '0;
         hr_wrap  = 1'b1;
      end else if (hr_o_q >= 4'd9) begin
         hr_o_inc = '0;
         hr_t_inc = hr_t_q + 2'd1;
      end
   end

   // Next-state: prescaler, tick cascade, set-mode edits
   always_comb begin
      presc_d     = presc_q;
      sec_o_d     = sec_o_q;
      sec_t_d     = sec_t_q;
      min_o_d     = min_o_q;
      min_t_d     = min_t_q;
      hr_o_d      = hr_o_q;
      hr_t_d      = hr_t_q;
      sec_pulse_d = 1'b0;
      day_wrap_d  = 1'b0;
      tick        = 1'b0;

      if (set_mode) begin
         presc_d = '0;
         if (!set_mode_q) begin
            sec_o_d = '0;
            sec_t_d = '0;
         end
         if (adj && !set_field) begin
            min_o_d = min_o_inc;
            min_t_d = min_t_inc;
         end else if (adj && set_field) begin
            hr_o_d = hr_o_inc;
            hr_t_d = hr_t_inc;
         end
      end else if (run) begin
         if (presc_q >= PMAX) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end

      if (tick) begin
         sec_pulse_d = 1'b1;
         sec_o_d     = sec_o_inc;
         sec_t_d     = sec_t_inc;
         if (sec_carry) begin
            min_o_d = min_o_inc;
            min_t_d = min_t_inc;
            if (min_carry) begin
               hr_o_d     = hr_o_inc;
               hr_t_d     = hr_t_inc;
               day_wrap_d = hr_wrap;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         set_mode_q  <= 1'b0;
         sec_o_q     <= '0;
         sec_t_q     <= '0;
         min_o_q     <= '0;
         min_t_q     <= '0;
         hr_o_q      <= '0;
         hr_t_q      <= '0;
         sec_pulse_q <= 1'b0;
         day_wrap_q  <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         set_mode_q  <= set_mode;
         sec_o_q     <= sec_o_d;
         sec_t_q     <= sec_t_d;
         min_o_q     <= min_o_d;
         min_t_q     <= min_t_d;
         hr_o_q      <= hr_o_d;
         hr_t_q      <= hr_t_d;
         sec_pulse_q <= sec_pulse_d;
         day_wrap_q  <= day_wrap_d;
      end
   end

   assign sec_o     = sec_o_q;
   assign sec_t     = sec_t_q;
   assign min_o     = min_o_q;
   assign min_t     = min_t_q;
   assign hr_o      = hr_o_q;
   assign hr_t      = hr_t_q;
   assign sec_pulse = sec_pulse_q;
   assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: time-of-day model in whole seconds, checked every
// cycle, plus directed scenarios with literal expectations.
module tb_hms_time_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       set_mode = 1'b0;
   logic       set_field = 1'b0;
   logic       adj = 1'b0;
   logic [3:0] sec_o, min_o, hr_o;
   logic [2:0] sec_t, min_t;
   logic [1:0] hr_t;
   logic       sec_pulse, day_wrap;

   int tests = 0;
   int fails = 0;

   hms_time_counter #(.CLK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .set_mode(set_mode), .set_field(set_field),
      .adj(adj), .sec_o(sec_o), .sec_t(sec_t), .min_o(min_o), .min_t(min_t),
      .hr_o(hr_o), .hr_t(hr_t), .sec_pulse(sec_pulse), .day_wrap(day_wrap)
   );

   initial forever #5 clk = ~clk;

   // Model: seconds of day, prescaler phase, previous set_mode
   int m_secs = 0, m_ph = 0;
   bit m_prev = 0, m_pulse = 0, m_wrap = 0;
   // Inputs as seen by the latest rising edge
   bit s_rst = 0, s_run = 0, s_set = 0, s_field = 0, s_adj = 0;

   function automatic int hhmmss();
      return hr_t * 100000 + hr_o * 10000 + min_t * 1000 + min_o * 100 + sec_t * 10 + sec_o;
   endfunction

   task automatic chk(string name, int got, int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      s_rst = rst_n; s_run = run; s_set = set_mode; s_field = set_field; s_adj = adj;
   end

   // Advance the model for the edge just passed, then compare every cycle
   initial forever begin
      int h, m, s, exp_t;
      @(negedge clk);
      if (!s_rst || !rst_n) begin
         m_secs = 0; m_ph = 0; m_prev = 0; m_pulse = 0; m_wrap = 0;
      end else begin
         m_pulse = 0; m_wrap = 0;
         h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
         if (s_set) begin
            m_ph = 0;
            if (!m_prev) s = 0;
            if (s_adj && !s_field) m = (m + 1) % 60;
            if (s_adj && s_field) h = (h + 1) % 24;
            m_secs = h * 3600 + m * 60 + s;
         end else if (s_run) begin
            if (m_ph == 3) begin
               m_ph = 0;
               m_secs = (m_secs + 1) % 86400;
               m_pulse = 1;
               m_wrap = (m_secs == 0);
            end else begin
               m_ph++;
            end
         end
         m_prev = s_set;
      end
      h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
      exp_t = (h / 10) * 100000 + (h % 10) * 10000 + (m / 10) * 1000 + (m % 10) * 100
              + (s / 10) * 10 + (s % 10);
      chk("model_time", hhmmss(), exp_t);
      chk("model_flags", {30'd0, sec_pulse, day_wrap}, {30'd0, m_pulse, m_wrap});
   end

   task automatic step(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_adj(bit field, int n);
      set_field = field;
      repeat (n) begin
         adj = 1'b1; step(1);
         adj = 1'b0; step(1);
      end
   endtask

   // Set hours/minutes in set mode, then run s ticks
   task automatic set_time(int h, int m, int s);
      int dh, dm;
      run = 1'b1;
      set_mode = 1'b1; step(1);
      dh = (h + 24 - m_secs / 3600) % 24;
      dm = (m + 60 - (m_secs / 60) % 60) % 60;
      pulse_adj(1'b1, dh);
      pulse_adj(1'b0, dm);
      set_mode = 1'b0;
      step(4 * s);
   endtask

   initial begin
      step(2);
      chk("reset_time", hhmmss(), 0);
      chk("reset_pulse", {31'd0, sec_pulse}, 0);
      chk("reset_wrap", {31'd0, day_wrap}, 0);

      // Free run from reset
      rst_n = 1'b1; run = 1'b1;
      step(3);
      chk("t1_before_tick", hhmmss(), 0);
      step(1);
      chk("t1_first_sec", hhmmss(), 1);
      chk("t1_pulse_hi", {31'd0, sec_pulse}, 1);
      step(1);
      chk("t1_pulse_lo", {31'd0, sec_pulse}, 0);
      step(35);
      chk("t1_ten_sec", hhmmss(), 10);

      // Minute-to-hour carry
      set_time(0, 59, 59);
      chk("t2_pre", hhmmss(), 5959);
      step(4);
      chk("t2_carry", hhmmss(), 10000);
      chk("t2_no_wrap", {31'd0, day_wrap}, 0);

      // Day wrap
      set_time(23, 59, 59);
      chk("t3_pre", hhmmss(), 235959);
      step(4);
      chk("t3_wrap_time", hhmmss(), 0);
      chk("t3_wrap_hi", {30'd0, day_wrap, sec_pulse}, 3);
      step(1);
      chk("t3_wrap_lo", {31'd0, day_wrap}, 0);

      // 24 hour adjustments return to the same hour
      set_time(0, 17, 0);
      set_mode = 1'b1; step(1);
      pulse_adj(1'b1, 24);
      chk("t4_hours_full_loop", hhmmss(), 1700);
      pulse_adj(1'b0, 43);
      chk("t4_min_wrap_no_carry", hhmmss(), 0);
      set_mode = 1'b0; step(1);

      // Entering set mode clears seconds; leaving restarts the prescaler
      set_time(12, 34, 56);
      chk("t5_pre", hhmmss(), 123456);
      step(2);
      set_mode = 1'b1; step(1);
      chk("t5_sec_clear", hhmmss(), 123400);
      step(20);
      chk("t5_hold", hhmmss(), 123400);
      set_mode = 1'b0; step(3);
      chk("t5_no_early_pulse", {31'd0, sec_pulse}, 0);
      step(1);
      chk("t5_first_pulse", {31'd0, sec_pulse}, 1);
      chk("t5_first_sec", hhmmss(), 123401);

      // Asynchronous reset mid-prescaler, then frozen
      set_time(9, 9, 9);
      step(2);
      rst_n = 1'b0; #1;
      chk("t6_async_reset", hhmmss(), 0);
      step(2);
      rst_n = 1'b1; run = 1'b0; step(20);
      chk("t6_frozen", hhmmss(), 0);
      chk("t6_frozen_pulse", {31'd0, sec_pulse}, 0);

      // Adjust works while frozen
      set_mode = 1'b1; step(1);
      pulse_adj(1'b1, 5);
      chk("t7_adj_no_run", hhmmss(), 50000);
      set_mode = 1'b0; step(1);

      // Random traffic; the per-cycle model compare does the checking
      for (int i = 0; i < 4000; i++) begin
         run = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
         set_field = $urandom_range(0, 1);
         adj = ($urandom_range(0, 3) == 0);
         step(1);
      end
      adj = 1'b0;
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
